// File: rtl/fpu_div16.sv
// Sequential FP16 divider: restoring significand division, one quotient bit per clock.
// Define FPU_DIV_RNE_EN for round-to-nearest-even; the default build truncates.
module fpu_div16 #(
  parameter int QBITS = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] fpuIn1,
  input  logic [15:0] fpuIn2,
  output logic [15:0] fpuOut,
  output logic        done,
  output logic [3:0]  condCodes
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLASSIFY = 3'd1;
  localparam logic [2:0] DIV      = 3'd2;
  localparam logic [2:0] NORM     = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]        state;
  logic [15:0]       op1, op2;
  logic [11:0]       rem;
  logic [QBITS-1:0]  quo;
  logic [3:0]        cnt;
  logic signed [6:0] expReg;
  logic              signReg;
  logic              specialReg;
  logic [15:0]       specialOut;
  logic [3:0]        specialCc;

  logic [4:0]  e1, e2;
  logic [9:0]  f1, f2;
  logic        zero1, zero2, inf1, inf2, nan1, nan2, sign;
  logic        isSpecial;
  logic [15:0] spOut;
  logic [3:0]  spCc;

  assign e1 = op1[14:10];
  assign e2 = op2[14:10];
  assign f1 = op1[9:0];
  assign f2 = op2[9:0];
  assign zero1 = (e1 == 5'd0);
  assign zero2 = (e2 == 5'd0);
  assign inf1  = (e1 == 5'd31) && (f1 == 10'd0);
  assign inf2  = (e2 == 5'd31) && (f2 == 10'd0);
  assign nan1  = (e1 == 5'd31) && (f1 != 10'd0);
  assign nan2  = (e2 == 5'd31) && (f2 != 10'd0);
  assign sign  = op1[15] ^ op2[15];

  // Special operand classes; subnormals count as zero. Dividing infinity by zero
  // is not a divide-by-zero event, so it yields infinity without C.
  always_comb begin
    isSpecial = 1'b1;
    spOut     = 16'h0000;
    spCc      = 4'b0000;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      spOut = 16'h7E00;
      spCc  = 4'b0001;
    end else if (zero2) begin
      spOut = {sign, 5'h1F, 10'h000};
      spCc  = {1'b0, ~inf1, sign, 1'b0};
    end else if (inf1) begin
      spOut = {sign, 5'h1F, 10'h000};
      spCc  = {2'b00, sign, 1'b0};
    end else if (inf2 || zero1) begin
      spOut = {sign, 15'h0000};
      spCc  = {1'b1, 1'b0, sign, 1'b0};
    end else begin
      isSpecial = 1'b0;
    end
  end

  logic [11:0] diff;
  logic        fits;

  assign fits = (rem >= {2'b01, f2});
  assign diff = rem - {2'b01, f2};

  logic              sticky, guard, rest, roundUp;
  logic [9:0]        mant;
  logic [10:0]       mantR;
  logic signed [6:0] eN, eF;
  logic [15:0]       normOut;
  logic [3:0]        normCc;

  always_comb begin
    sticky = (rem != 12'd0);
    if (quo[QBITS-1]) begin
      mant  = quo[QBITS-2 -: 10];
      guard = quo[QBITS-12];
      rest  = (|quo[QBITS-13:0]) | sticky;
      eN    = expReg;
    end else begin
      mant  = quo[QBITS-3 -: 10];
      guard = quo[QBITS-13];
      rest  = (|quo[QBITS-14:0]) | sticky;
      eN    = expReg - 7'sd1;
    end
`ifdef FPU_DIV_RNE_EN
    roundUp = guard && (rest || mant[0]);
`else
    roundUp = guard & rest & 1'b0;
`endif
    mantR = {1'b0, mant} + {10'd0, roundUp};
    eF    = mantR[10] ? (eN + 7'sd1) : eN;
    if (eF >= 7'sd31) begin
      normOut = {signReg, 5'h1F, 10'h000};
      normCc  = {2'b00, signReg, 1'b1};
    end else if (eF <= 7'sd0) begin
      normOut = {signReg, 15'h0000};
      normCc  = {1'b1, 1'b0, signReg, 1'b0};
    end else begin
      normOut = {signReg, eF[4:0], mantR[9:0]};
      normCc  = {2'b00, signReg, 1'b0};
    end
  end

  // Special results travel through NORM as well, so writeback happens in one place.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op1        <= 16'h0000;
      op2        <= 16'h0000;
      rem        <= 12'd0;
      quo        <= '0;
      cnt        <= 4'd0;
      expReg     <= 7'sd0;
      signReg    <= 1'b0;
      specialReg <= 1'b0;
      specialOut <= 16'h0000;
      specialCc  <= 4'b0000;
      fpuOut     <= 16'h0000;
      condCodes  <= 4'b0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op1   <= fpuIn1;
            op2   <= fpuIn2;
            state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          specialReg <= isSpecial;
          specialOut <= spOut;
          specialCc  <= spCc;
          signReg    <= sign;
          rem        <= {2'b01, f1};
          quo        <= '0;
          cnt        <= 4'd0;
          expReg     <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 7'sd15;
          state      <= isSpecial ? NORM : DIV;
        end
        DIV: begin
          if (fits) begin
            rem <= {diff[10:0], 1'b0};
            quo <= {quo[QBITS-2:0], 1'b1};
          end else begin
            rem <= {rem[10:0], 1'b0};
            quo <= {quo[QBITS-2:0], 1'b0};
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'(QBITS - 1)) state <= NORM;
        end
        NORM: begin
          fpuOut    <= specialReg ? specialOut : normOut;
          condCodes <= specialReg ? specialCc : normCc;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_fpu_div16.sv
// Randomised and directed bench for fpu_div16 against an arithmetic FP16 divide model.
module tb_fpu_div16;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] fpuIn1;
  logic [15:0] fpuIn2;
  logic [15:0] fpuOut;
  logic        done;
  logic [3:0]  condCodes;

  int checkCount;
  int failCount;

  fpu_div16 dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .fpuIn1    (fpuIn1),
    .fpuIn2    (fpuIn2),
    .fpuOut    (fpuOut),
    .done      (done),
    .condCodes (condCodes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Result as {condCodes, fpuOut}; lat is the expected start-to-done edge count.
  function automatic logic [19:0] refDiv(input logic [15:0] a, input logic [15:0] b, output int lat);
    int ea, eb, fa, fb, m1, m2, q, r, e, mant, g, rest;
    bit s, za, zb, ia, ib, na, nb;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    lat = 2;
    if (na || nb || (za && zb) || (ia && ib)) return {4'b0001, 16'h7E00};
    if (zb) return {1'b0, ~ia, s, 1'b0, s, 15'h7C00};
    if (ia) return {2'b00, s, 1'b0, s, 15'h7C00};
    if (ib || za) return {2'b10, s, 1'b0, s, 15'h0000};
    lat = 16;
    m1 = 1024 + fa; m2 = 1024 + fb;
    q = (m1 * 8192) / m2;
    r = (m1 * 8192) % m2;
    e = ea - eb + 15;
    if (q >= 8192) begin
      mant = (q / 8) % 1024; g = (q / 4) % 2; rest = ((q % 4) != 0 || r != 0) ? 1 : 0;
    end else begin
      e = e - 1;
      mant = (q / 4) % 1024; g = (q / 2) % 2; rest = ((q % 2) != 0 || r != 0) ? 1 : 0;
    end
`ifdef FPU_DIV_RNE_EN
    if (g == 1 && (rest == 1 || (mant % 2) == 1)) mant = mant + 1;
`endif
    if (mant == 1024) begin
      mant = 0; e = e + 1;
    end
    if (e >= 31) return {2'b00, s, 1'b1, s, 15'h7C00};
    if (e <= 0) return {2'b10, s, 1'b0, s, 15'h0000};
    return {2'b00, s, 1'b0, s, 5'(e), 10'(mant)};
  endfunction

  // One operation; inputs are scrambled after acceptance, optional start pulse mid-divide.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit pulse,
                               output logic [15:0] outV, output logic [3:0] ccV, output int lat);
    @(negedge clock);
    fpuIn1 = a;
    fpuIn2 = b;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    fpuIn1 = 16'($urandom);
    fpuIn2 = 16'($urandom);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      if (pulse && k == 5) begin
        fpuIn1 = 16'h4600;
        fpuIn2 = 16'h3C00;
        start  = 1'b1;
      end
      if (pulse && k == 6) start = 1'b0;
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    outV  = fpuOut;
    ccV   = condCodes;
  endtask

  function automatic logic [15:0] randOperand();
    logic [4:0] e;
    logic [9:0] f;
    int sel;
    sel = int'($urandom_range(0, 9));
    f = 10'($urandom);
    if (sel == 0) e = 5'd0;
    else if (sel == 1) begin
      e = 5'd31;
      if ($urandom_range(0, 1) == 0) f = 10'd0;
    end else e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, f};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  cc;
    int          lat;
    string       tag;
  } dirCase_t;

  dirCase_t dirCases[$];

  initial begin
    logic [15:0] o;
    logic [3:0]  c;
    logic [19:0] exp20;
    int          lat, expLat;
    logic [15:0] a, b;

    checkCount = 0;
    failCount  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    fpuIn1 = 16'h0000;
    fpuIn2 = 16'h0000;
    #12;
    checkOutput("reset fpuOut", 32'(fpuOut), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset condCodes", 32'(condCodes), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    dirCases.push_back('{16'h3C00, 16'h4000, 16'h3800, 4'b0000, 16, "1/2"});
    dirCases.push_back('{16'h4600, 16'hBE00, 16'hC400, 4'b0010, 16, "6/-1.5"});
`ifdef FPU_DIV_RNE_EN
    dirCases.push_back('{16'h4500, 16'h4200, 16'h3EAB, 4'b0000, 16, "5/3"});
`else
    dirCases.push_back('{16'h4500, 16'h4200, 16'h3EAA, 4'b0000, 16, "5/3"});
`endif
    dirCases.push_back('{16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 2, "1/0"});
    dirCases.push_back('{16'h0000, 16'h0000, 16'h7E00, 4'b0001, 2, "0/0"});
    dirCases.push_back('{16'h7BFF, 16'h3000, 16'h7C00, 4'b0001, 16, "overflow"});
    dirCases.push_back('{16'h0400, 16'h7800, 16'h0000, 4'b1000, 16, "underflow"});
    dirCases.push_back('{16'hC000, 16'h7C00, 16'h8000, 4'b1010, 2, "-2/inf"});

    foreach (dirCases[i]) begin
      applyStimulus(dirCases[i].a, dirCases[i].b, 1'b0, o, c, lat);
      checkOutput({dirCases[i].tag, " out"}, 32'(o), 32'(dirCases[i].out));
      checkOutput({dirCases[i].tag, " cc"}, 32'(c), 32'(dirCases[i].cc));
      checkOutput({dirCases[i].tag, " latency"}, 32'(lat), 32'(dirCases[i].lat));
    end

    // Reset asserted in the fifth divide cycle of 5/3.
    @(negedge clock);
    fpuIn1 = 16'h4500;
    fpuIn2 = 16'h4200;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("hold old fpuOut", 32'(fpuOut), 32'h8000);
    checkOutput("busy done", 32'(done), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midop reset fpuOut", 32'(fpuOut), 32'h0);
    checkOutput("midop reset done", 32'(done), 32'h0);
    checkOutput("midop reset cc", 32'(condCodes), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(16'h3C00, 16'h4000, 1'b1, o, c, lat);
    checkOutput("restart out", 32'(o), 32'h3800);
    checkOutput("restart cc", 32'(c), 32'h0);
    checkOutput("restart latency", 32'(lat), 32'd16);

    for (int n = 0; n < 60; n++) begin
      a = randOperand();
      b = randOperand();
      exp20 = refDiv(a, b, expLat);
      applyStimulus(a, b, 1'($urandom_range(0, 1)), o, c, lat);
      checkOutput($sformatf("rand %04h/%04h out", a, b), 32'(o), 32'(exp20[15:0]));
      checkOutput($sformatf("rand %04h/%04h cc", a, b), 32'(c), 32'(exp20[19:16]));
      checkOutput($sformatf("rand %04h/%04h latency", a, b), 32'(lat), 32'(expLat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
